// File: rtl/rasterizer_writeback_logic.sv
// End-of-pipe writeback: buffers depth-fetched fragments, applies the depth test and
// issues depth-then-color Avalon-MM writes. Optional macro: RASTER_DEPTH_TEST_EN.
module rasterizer_writeback_logic #(
  parameter int FIFO_DEPTH = 8,
  parameter int SLACK      = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [25:0] addr_in,
  input  logic [23:0] color_in,
  input  logic [31:0] new_depth_in,
  input  logic [31:0] old_depth_in,
  input  logic        done_in,
  output logic        stall_out,
  output logic        done_out,
  output logic [25:0] master_address,
  output logic        master_write,
  output logic        master_read,
  output logic [3:0]  master_byteenable,
  output logic [31:0] master_writedata,
  input  logic        master_waitrequest,
  output logic        overflow,
  output logic [31:0] pix_written,
  output logic [31:0] pix_rejected
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int ENTRY_W = 115;
  localparam logic [PTR_W:0] DEPTH_C  = FIFO_DEPTH[PTR_W:0];
  localparam logic [PTR_W:0] THRESH_C = (FIFO_DEPTH - SLACK);

  typedef enum logic [1:0] {S_IDLE, S_WR_DEPTH, S_WR_COLOR} state_t;

  state_t             state;
  logic [ENTRY_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W:0]     count;
  logic               full;
  logic               push;
  logic               pop;

  logic [ENTRY_W-1:0] head;
  logic [25:0]        head_addr;
  logic [23:0]        head_color;
  logic [31:0]        head_new;
  logic [31:0]        head_old;
  logic               head_done;
  logic               head_pass;

  logic [25:0]        work_addr;
  logic [23:0]        work_color;
  logic               work_done;

  assign full      = (count == DEPTH_C);
  assign push      = in_valid && !full;
  assign pop       = (state == S_IDLE) && (count != '0);
  assign stall_out = (count >= THRESH_C);
  assign master_read = 1'b0;

  assign head       = fifo_mem[rd_ptr];
  assign head_addr  = head[25:0];
  assign head_color = head[49:26];
  assign head_new   = head[81:50];
  assign head_old   = head[113:82];
  assign head_done  = head[114];

`ifdef RASTER_DEPTH_TEST_EN
  assign head_pass = (head_new < head_old);
`else
  // Test disabled: every fragment is written; the stored old depth has no consumer.
  logic unused_old_depth;
  assign unused_old_depth = ^head_old;
  assign head_pass = 1'b1;
`endif

  // Storage carries no reset so it can map onto distributed RAM; validity lives in count.
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_mem[wr_ptr] <= {done_in, old_depth_in, new_depth_in, color_in, addr_in};
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (in_valid && full) begin
        overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state             <= S_IDLE;
      master_write      <= 1'b0;
      master_address    <= '0;
      master_writedata  <= '0;
      master_byteenable <= '0;
      done_out          <= 1'b0;
      pix_written       <= '0;
      pix_rejected      <= '0;
      work_addr         <= '0;
      work_color        <= '0;
      work_done         <= 1'b0;
    end else begin
      done_out <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pop) begin
            if (head_pass) begin
              state             <= S_WR_DEPTH;
              master_write      <= 1'b1;
              master_address    <= head_addr + 26'd4;
              master_writedata  <= head_new;
              master_byteenable <= 4'b1111;
              work_addr         <= head_addr;
              work_color        <= head_color;
              work_done         <= head_done;
            end else begin
              // A rejected fragment retires on the decision edge itself.
              pix_rejected <= pix_rejected + 32'd1;
              done_out     <= head_done;
            end
          end
        end
        S_WR_DEPTH: begin
          if (!master_waitrequest) begin
            state             <= S_WR_COLOR;
            master_address    <= work_addr;
            master_writedata  <= {8'h00, work_color};
            master_byteenable <= 4'b0111;
          end
        end
        S_WR_COLOR: begin
          if (!master_waitrequest) begin
            state        <= S_IDLE;
            master_write <= 1'b0;
            pix_written  <= pix_written + 32'd1;
            done_out     <= work_done;
          end
        end
        default: begin
          state        <= S_IDLE;
          master_write <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rasterizer_writeback_logic.sv
// Directed bench for rasterizer_writeback_logic: single write, reject/pass, waitrequest
// hold, FIFO back-pressure with overflow, and asynchronous reset mid-transfer.
module tb_rasterizer_writeback_logic;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [25:0] addr_in;
  logic [23:0] color_in;
  logic [31:0] new_depth_in;
  logic [31:0] old_depth_in;
  logic        done_in;
  logic        stall_out;
  logic        done_out;
  logic [25:0] master_address;
  logic        master_write;
  logic        master_read;
  logic [3:0]  master_byteenable;
  logic [31:0] master_writedata;
  logic        master_waitrequest;
  logic        overflow;
  logic [31:0] pix_written;
  logic [31:0] pix_rejected;

  int vectors = 0;
  int miscompares = 0;
  int exp_written = 0;
  logic [61:0] beats [$];

  rasterizer_writeback_logic #(.FIFO_DEPTH(8), .SLACK(2)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .addr_in(addr_in),
    .color_in(color_in), .new_depth_in(new_depth_in), .old_depth_in(old_depth_in),
    .done_in(done_in), .stall_out(stall_out), .done_out(done_out),
    .master_address(master_address), .master_write(master_write),
    .master_read(master_read), .master_byteenable(master_byteenable),
    .master_writedata(master_writedata), .master_waitrequest(master_waitrequest),
    .overflow(overflow), .pix_written(pix_written), .pix_rejected(pix_rejected)
  );

  always #5 clock = ~clock;

  // Inputs only change 1ns after a rising edge, so a beat seen here is accepted next edge.
  always @(negedge clock) begin
    if (reset && master_write && !master_waitrequest) begin
      beats.push_back({master_address, master_writedata, master_byteenable});
      $display("beat addr=%h data=%h be=%h", master_address, master_writedata, master_byteenable);
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [25:0] a, input logic [23:0] c, input logic [31:0] nd,
                      input logic [31:0] od, input logic d);
    in_valid = 1'b1; addr_in = a; color_in = c; new_depth_in = nd; old_depth_in = od; done_in = d;
    tick();
    in_valid = 1'b0;
    $display("send addr=%h color=%h new=%0d old=%0d done=%0b", a, c, nd, od, d);
  endtask

  initial begin
    int wait_cnt;
    reset = 1'b0; in_valid = 1'b0; addr_in = '0; color_in = '0; new_depth_in = '0;
    old_depth_in = '0; done_in = 1'b0; master_waitrequest = 1'b0;

    // Reset state
    #2;
    check("rst_write", master_write, 0);
    check("rst_addr", master_address, 0);
    check("rst_data", master_writedata, 0);
    check("rst_be", master_byteenable, 0);
    check("rst_stall", stall_out, 0);
    check("rst_done", done_out, 0);
    check("rst_ovf", overflow, 0);
    check("rst_written", pix_written, 0);
    check("rst_rejected", pix_rejected, 0);
    check("rst_read", master_read, 0);
    tick(); tick();
    reset = 1'b1;
    tick();

    // Single passing fragment, no wait
    beats.delete();
    send(26'h100, 24'hA1B2C3, 32'd5, 32'd9, 1'b0);
    check("t1_latency_idle", master_write, 0);
    tick();
    check("t1_depth_write", master_write, 1);
    check("t1_depth_addr", master_address, 26'h104);
    check("t1_depth_data", master_writedata, 32'd5);
    check("t1_depth_be", master_byteenable, 4'hF);
    tick();
    check("t1_color_addr", master_address, 26'h100);
    check("t1_color_data", master_writedata, 32'h00A1B2C3);
    check("t1_color_be", master_byteenable, 4'h7);
    tick();
    exp_written = 1;
    check("t1_write_low", master_write, 0);
    check("t1_written", pix_written, exp_written);
    check("t1_nbeats", beats.size(), 2);
    if (beats.size() == 2) begin
      check("t1_beat0", beats[0], {26'h104, 32'd5, 4'hF});
      check("t1_beat1", beats[1], {26'h100, 32'h00A1B2C3, 4'h7});
    end

`ifdef RASTER_DEPTH_TEST_EN
    // Equal depths fail the strict test; done pulses one cycle after the pop
    beats.delete();
    send(26'h200, 24'h010203, 32'd9, 32'd9, 1'b1);
    check("t2_pre_done", done_out, 0);
    tick();
    check("t2_done_pulse", done_out, 1);
    check("t2_rejected", pix_rejected, 1);
    check("t2_no_write", master_write, 0);
    tick();
    check("t2_done_clear", done_out, 0);
    tick();
    check("t2_nbeats", beats.size(), 0);
    check("t2_written", pix_written, exp_written);
`else
    // Without the test, a deeper fragment is still written
    beats.delete();
    send(26'h200, 24'h010203, 32'd20, 32'd3, 1'b1);
    tick(); tick();
    check("t2_pre_done", done_out, 0);
    tick();
    exp_written = 2;
    check("t2_done_pulse", done_out, 1);
    check("t2_written", pix_written, exp_written);
    check("t2_write_low", master_write, 0);
    tick();
    check("t2_done_clear", done_out, 0);
    check("t2_rejected", pix_rejected, 0);
    check("t2_nbeats", beats.size(), 2);
    if (beats.size() == 2) begin
      check("t2_beat0", beats[0], {26'h204, 32'd20, 4'hF});
      check("t2_beat1", beats[1], {26'h200, 32'h00010203, 4'h7});
    end
`endif

    // Waitrequest held three cycles on the depth beat
    beats.delete();
    master_waitrequest = 1'b1;
    send(26'h300, 24'h123456, 32'd7, 32'd100, 1'b0);
    tick();
    for (int i = 0; i < 4; i++) begin
      check("t3_hold_write", master_write, 1);
      check("t3_hold_addr", master_address, 26'h304);
      check("t3_hold_data", master_writedata, 32'd7);
      check("t3_hold_be", master_byteenable, 4'hF);
      if (i == 3) master_waitrequest = 1'b0;
      tick();
    end
    check("t3_color_addr", master_address, 26'h300);
    check("t3_color_data", master_writedata, 32'h00123456);
    tick();
    exp_written++;
    check("t3_write_low", master_write, 0);
    check("t3_written", pix_written, exp_written);
    check("t3_nbeats", beats.size(), 2);

    // Back-pressure: FSM parked on a stuck depth beat, then nine more records
    beats.delete();
    master_waitrequest = 1'b1;
    send(26'h400, 24'd0, 32'd0, 32'hFFFF_FFFF, 1'b0);
    tick();
    for (int k = 1; k <= 9; k++) begin
      in_valid = 1'b1; addr_in = 26'h400 + 26'(16 * k); color_in = 24'(k);
      new_depth_in = 32'(k); old_depth_in = 32'hFFFF_FFFF; done_in = 1'b0;
      tick();
      check($sformatf("t4_stall_%0d", k), stall_out, ((k >= 6) ? 1 : 0));
      check($sformatf("t4_ovf_%0d", k), overflow, ((k == 9) ? 1 : 0));
    end
    in_valid = 1'b0;
    master_waitrequest = 1'b0;
    exp_written += 9;
    wait_cnt = 0;
    while (pix_written !== 32'(exp_written) && wait_cnt < 200) begin
      tick();
      wait_cnt++;
    end
    check("t4_drain_written", pix_written, exp_written);
    tick();
    check("t4_stall_clear", stall_out, 0);
    check("t4_ovf_sticky", overflow, 1);
    check("t4_nbeats", beats.size(), 18);
    if (beats.size() == 18) begin
      for (int j = 0; j < 9; j++) begin
        check($sformatf("t4_order_%0d", j), beats[2*j][61:36], 26'h404 + 26'(16 * j));
        check($sformatf("t4_color_%0d", j), beats[2*j+1][35:4], 32'(j));
      end
    end

    // Reset asserted during the color beat
    send(26'h500, 24'hABCDEF, 32'd1, 32'd2, 1'b0);
    tick(); tick();
    master_waitrequest = 1'b1;
    check("t5_color_write", master_write, 1);
    check("t5_color_addr", master_address, 26'h500);
    #2;
    reset = 1'b0;
    #1;
    check("t5_async_drop", master_write, 0);
    beats.delete();
    tick(); tick();
    reset = 1'b1;
    master_waitrequest = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    check("t5_no_stale", beats.size(), 0);
    check("t5_write", master_write, 0);
    check("t5_written", pix_written, 0);
    check("t5_rejected", pix_rejected, 0);
    check("t5_ovf", overflow, 0);
    check("t5_stall", stall_out, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
